// File: rtl/spike_pkg.sv
// Shared types and defaults for the spike winner selector.
// The SPIKE_COUNT_EN build adds a popcount of each accepted vector.
package spike_pkg;

  localparam int NUM_NEURONS_DEFAULT = 100;
  localparam int IDX_W_DEFAULT       = 7;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } sel_state_t;

endpackage

// File: rtl/spike_popcount.sv
// Combinational population count of a spike vector.
// Used only when SPIKE_COUNT_EN is defined.
module spike_popcount #(
  parameter int NUM_NEURONS = 100,
  parameter int CNT_W       = 7
) (
  input  logic [NUM_NEURONS-1:0] vec,
  output logic [CNT_W-1:0]       count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      count = count + CNT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/spike_winner_selector.sv
// Picks one active neuron by a wrapped scan from a random start index.
// Define SPIKE_COUNT_EN to add the spike_count output (popcount of vector).
module spike_winner_selector
  import spike_pkg::*;
#(
  parameter int NUM_NEURONS = NUM_NEURONS_DEFAULT,
  parameter int IDX_W       = IDX_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_NEURONS-1:0] spike_vec,
  input  logic [IDX_W-1:0]       rand_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   winner_valid,
  output logic [IDX_W-1:0]       winner_idx,
  output logic                   no_spike,
  output logic                   lfsr_advance
`ifdef SPIKE_COUNT_EN
  ,
  output logic [IDX_W-1:0]       spike_count
`endif
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

  sel_state_t             state_q, state_d;
  logic [NUM_NEURONS-1:0] vec_q, vec_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   valid_q, valid_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   nosp_q, nosp_d;
  logic                   adv_q, adv_d;
  logic [IDX_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       pop;

`ifdef SPIKE_COUNT_EN
  spike_popcount #(
    .NUM_NEURONS (NUM_NEURONS),
    .CNT_W       (IDX_W)
  ) u_pop (
    .vec   (spike_vec),
    .count (pop)
  );
  assign spike_count = cnt_q;
`else
  assign pop = '0;
`endif

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    adv_d   = 1'b0;
    valid_d = valid_q;
    idx_d   = idx_q;
    nosp_d  = nosp_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          vec_d   = spike_vec;
          valid_d = 1'b0;
          nosp_d  = 1'b0;
          cnt_d   = pop;
          ptr_d   = (rand_idx <= LAST) ? rand_idx : '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // An empty vector spends one scan cycle, matching the d=0 latency
        if (vec_q == '0) begin
          nosp_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          adv_d   = 1'b1;
          state_d = DONE;
        end else if (vec_q[ptr_q]) begin
          idx_d   = ptr_q;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          adv_d   = 1'b1;
          state_d = DONE;
        end else begin
          ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      nosp_q  <= 1'b0;
      adv_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      nosp_q  <= nosp_d;
      adv_q   <= adv_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign winner_valid = valid_q;
  assign winner_idx   = idx_q;
  assign no_spike     = nosp_q;
  assign lfsr_advance = adv_q;

endmodule

// File: tb/tb_spike_winner_selector.sv
// Bench for spike_winner_selector: vector table, scoreboard queue,
// plus directed mid-scan restart and mid-scan reset sequences.
module tb_spike_winner_selector;

  localparam int N = 100;
  localparam int W = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] spike_vec;
  logic [W-1:0] rand_idx;
  logic         busy;
  logic         done;
  logic         winner_valid;
  logic [W-1:0] winner_idx;
  logic         no_spike;
  logic         lfsr_advance;
`ifdef SPIKE_COUNT_EN
  logic [W-1:0] spike_count;
`endif

  always #5 clk = ~clk;

  spike_winner_selector #(
    .NUM_NEURONS (N),
    .IDX_W       (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .spike_vec    (spike_vec),
    .rand_idx     (rand_idx),
    .busy         (busy),
    .done         (done),
    .winner_valid (winner_valid),
    .winner_idx   (winner_idx),
    .no_spike     (no_spike),
    .lfsr_advance (lfsr_advance)
`ifdef SPIKE_COUNT_EN
    ,
    .spike_count  (spike_count)
`endif
  );

  typedef struct {
    logic [W-1:0] idx;
    logic         valid;
    logic         ns;
    int           lat;
    int           cnt;
  } exp_t;

  typedef struct {
    logic [N-1:0] vec;
    logic [W-1:0] ridx;
    exp_t         e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] bit_(input int b);
    logic [N-1:0] v;
    v    = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  // Reference: first set bit walking up from the (capped) start, wrapping
  function automatic exp_t model(input logic [N-1:0] v,
                                 input logic [W-1:0] r,
                                 input logic [W-1:0] prev);
    int s;
    int p;
    s = (int'(r) < N) ? int'(r) : 0;
    for (int i = 0; i < N; i++) begin
      p = (s + i) % N;
      if (v[p]) return '{W'(p), 1'b1, 1'b0, i + 1, $countones(v)};
    end
    return '{prev, 1'b0, 1'b1, 1, 0};
  endfunction

  task automatic run_one(input logic [N-1:0] v, input logic [W-1:0] r,
                         input exp_t e, input int restart_at,
                         input logic [N-1:0] alt);
    int   k;
    int   bcnt;
    int   spur;
    bit   seen;
    exp_t g;
    @(negedge clk);
    spike_vec = v;
    rand_idx  = r;
    start     = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start     = 1'b0;
    spike_vec = ~v;
    rand_idx  = W'($urandom_range(0, 127));
`ifdef SPIKE_COUNT_EN
    chk("spike_count_e0", int'(spike_count), e.cnt);
`endif
    k    = 0;
    bcnt = 0;
    spur = 0;
    seen = 1'b0;
    while (k <= N + 2) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) bcnt++;
      if (lfsr_advance) spur++;
      if (k == restart_at) begin
        spike_vec = alt;
        rand_idx  = 7'd10;
        start     = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("done_seen", int'(seen), 1);
    chk("adv_early", spur, 0);
    if (sb.size() != 0) begin
      g = sb.pop_front();
      if (seen) begin
        chk("latency", k, g.lat);
        chk("busy_cycles", bcnt, g.lat);
        chk("busy_at_done", int'(busy), 0);
        chk("lfsr_advance", int'(lfsr_advance), 1);
        chk("winner_valid", int'(winner_valid), int'(g.valid));
        chk("winner_idx", int'(winner_idx), int'(g.idx));
        chk("no_spike", int'(no_spike), int'(g.ns));
`ifdef SPIKE_COUNT_EN
        chk("spike_count", int'(spike_count), g.cnt);
`endif
        @(negedge clk);
        chk("done_pulse", int'(done), 0);
        chk("adv_pulse", int'(lfsr_advance), 0);
        chk("idx_held", int'(winner_idx), int'(g.idx));
        chk("valid_held", int'(winner_valid), int'(g.valid));
      end
    end
  endtask

  initial begin
    logic [N-1:0] v;
    logic [W-1:0] r;
    logic [W-1:0] prev;
    exp_t         e;
    int           pulses;

    reset     = 1'b1;
    start     = 1'b0;
    spike_vec = '0;
    rand_idx  = '0;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(winner_valid), 0);
    chk("rst_idx", int'(winner_idx), 0);
    chk("rst_nospike", int'(no_spike), 0);
    chk("rst_adv", int'(lfsr_advance), 0);
    @(negedge clk);
    reset = 1'b0;

    tbl.push_back('{bit_(42), 7'd40, '{7'd42, 1'b1, 1'b0, 3, 1}});
    tbl.push_back('{bit_(5), 7'd98, '{7'd5, 1'b1, 1'b0, 8, 1}});
    tbl.push_back('{'0, 7'd17, '{7'd5, 1'b0, 1'b1, 1, 0}});
    tbl.push_back('{bit_(0) | bit_(50), 7'd100,
                    '{7'd0, 1'b1, 1'b0, 1, 2}});
    tbl.push_back('{bit_(99), 7'd127, '{7'd99, 1'b1, 1'b0, 100, 1}});
    tbl.push_back('{'1, 7'd99, '{7'd99, 1'b1, 1'b0, 1, 100}});
    tbl.push_back('{bit_(50), 7'd51, '{7'd50, 1'b1, 1'b0, 100, 1}});
    tbl.push_back('{'0, 7'd0, '{7'd50, 1'b0, 1'b1, 1, 0}});
    tbl.push_back('{bit_(3) | bit_(7) | bit_(64) | bit_(99), 7'd65,
                    '{7'd99, 1'b1, 1'b0, 35, 4}});

    prev = 7'd99;
    for (int i = 0; i < 6; i++) begin
      v = '0;
      repeat ($urandom_range(0, 4)) v[$urandom_range(0, N - 1)] = 1'b1;
      r = W'($urandom_range(0, 127));
      e = model(v, r, prev);
      prev = e.idx;
      tbl.push_back('{v, r, e});
    end

    foreach (tbl[i]) run_one(tbl[i].vec, tbl[i].ridx, tbl[i].e, -1, '0);

    // Start re-pulsed mid-scan with another vector must be ignored
    run_one(bit_(90), 7'd0, '{7'd90, 1'b1, 1'b0, 91, 1}, 5, bit_(10));

    // Reset mid-scan clears outputs at once and suppresses completion
    @(negedge clk);
    spike_vec = bit_(60);
    rand_idx  = 7'd0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_valid", int'(winner_valid), 0);
    chk("mid_rst_idx", int'(winner_idx), 0);
    chk("mid_rst_nospike", int'(no_spike), 0);
    chk("mid_rst_adv", int'(lfsr_advance), 0);
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    repeat (110) begin
      @(negedge clk);
      if (done || lfsr_advance || busy) pulses++;
    end
    chk("post_rst_quiet", pulses, 0);

    // Empty vector after reset keeps the cleared index
    run_one('0, 7'd33, '{7'd0, 1'b0, 1'b1, 1, 0}, -1, '0);
    run_one(bit_(1), 7'd2, '{7'd1, 1'b1, 1'b0, 100, 1}, -1, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
